// File: rtl/memu.sv
// Memory-access stage: one-slot buffer between EX and WB that issues a single
// data-memory request per load/store. Optional MEMU_ALIGN_CHECK_EN flags misaligned accesses.
module memu (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready,
  input  logic [31:0] Ex_result_in,
  input  logic [31:0] rs2_value_in,
  input  logic        mem_ren_in,
  input  logic        mem_wen_in,
  input  logic [2:0]  mem_op_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] rd_value_in,
  input  logic [3:0]  csr_wen_in,
  input  logic        R_wen_in,
  input  logic        jump_flag_in,
  input  logic [31:0] pc_in,
  output logic        valid_next,
  input  logic        ready_in,
  output logic [31:0] MEM_Rdata_out,
  output logic [31:0] Ex_result_out,
  output logic [31:0] rd_value_out,
  output logic [4:0]  rd_out,
  output logic [3:0]  csr_wen_out,
  output logic        R_wen_out,
  output logic        mem_ren_out,
  output logic        jump_flag_out,
  output logic [31:0] pc_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        misalign_out,
  output logic [1:0]  dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; upstream is valid_in/ready, downstream is valid_next/ready_in.
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_WAIT = 2'd1, S_FULL = 2'd2} state_t;

  state_t      r_state, w_next;
  logic        w_accept, w_is_mem, w_mis;
  logic [31:0] r_ex, r_rs2, r_rd_value, r_pc, r_rdata;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [3:0]  r_csr_wen;
  logic        r_ren, r_wen, r_R_wen, r_jump;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_accept = valid_in & ready;
  assign w_is_mem = mem_ren_in | mem_wen_in;

`ifdef MEMU_ALIGN_CHECK_EN
  logic w_in_byte, w_in_half, r_mis;
  // Opcodes 100/101 only mean byte/half for loads; stores treat them as words.
  assign w_in_byte = (mem_op_in == 3'b000) | (mem_ren_in & (mem_op_in == 3'b100));
  assign w_in_half = (mem_op_in == 3'b001) | (mem_ren_in & (mem_op_in == 3'b101));
  assign w_mis = w_is_mem & ((w_in_half & Ex_result_in[0]) |
                 (~w_in_half & ~w_in_byte & (Ex_result_in[1:0] != 2'b00)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_mis <= 1'b0;
    else if (w_accept) r_mis <= w_mis;
  end
  assign misalign_out = r_mis;
`else
  assign w_mis        = 1'b0;
  assign misalign_out = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY: if (valid_in) w_next = (w_is_mem & ~w_mis) ? S_WAIT : S_FULL;
      S_WAIT:  if (dmem_ack) w_next = S_FULL;
      S_FULL:  if (ready_in) w_next = !valid_in ? S_EMPTY :
                                      (w_is_mem & ~w_mis) ? S_WAIT : S_FULL;
      default: w_next = S_EMPTY;
    endcase
  end

  always_comb begin
    ready      = (r_state == S_EMPTY) | ((r_state == S_FULL) & ready_in);
    valid_next = (r_state == S_FULL);
    dmem_req   = (r_state == S_WAIT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ex <= '0; r_rs2 <= '0; r_op <= '0; r_ren <= 1'b0; r_wen <= 1'b0;
      r_rd <= '0; r_rd_value <= '0; r_csr_wen <= '0; r_R_wen <= 1'b0;
      r_jump <= 1'b0; r_pc <= '0; r_rdata <= '0;
    end else if (w_accept) begin
      r_ex       <= Ex_result_in;
      r_rs2      <= rs2_value_in;
      r_op       <= mem_op_in;
      r_ren      <= mem_ren_in & ~w_mis;
      r_wen      <= mem_wen_in & ~w_mis;
      r_rd       <= rd_in;
      r_rd_value <= rd_value_in;
      r_csr_wen  <= csr_wen_in;
      r_R_wen    <= R_wen_in & ~w_mis;
      r_jump     <= jump_flag_in;
      r_pc       <= pc_in;
      r_rdata    <= '0;
    end else if ((r_state == S_WAIT) && dmem_ack) begin
      r_rdata <= r_ren ? w_load : '0;
    end
  end

  // Lane selection uses the byte address; halves ignore addr[0], words ignore [1:0].
  always_comb begin
    case (r_ex[1:0])
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_ex[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_op)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  always_comb begin
    case (r_op)
      3'b000: begin
        dmem_wstrb = 4'b0001 << r_ex[1:0];
        dmem_wdata = {4{r_rs2[7:0]}};
      end
      3'b001: begin
        dmem_wstrb = 4'b0011 << {r_ex[1], 1'b0};
        dmem_wdata = {2{r_rs2[15:0]}};
      end
      default: begin
        dmem_wstrb = 4'b1111;
        dmem_wdata = r_rs2;
      end
    endcase
  end

  assign dmem_we       = r_wen;
  assign dmem_addr     = {r_ex[31:2], 2'b00};
  assign MEM_Rdata_out = r_rdata;
  assign Ex_result_out = r_ex;
  assign rd_value_out  = r_rd_value;
  assign rd_out        = r_rd;
  assign csr_wen_out   = r_csr_wen;
  assign R_wen_out     = r_R_wen;
  assign mem_ren_out   = r_ren;
  assign jump_flag_out = r_jump;
  assign pc_out        = r_pc;
  assign dbg_state     = r_state;
endmodule

// File: tb/tb_memu.sv
// Bench for memu: transaction-level slot model, per-cycle compare, directed
// cases with literal expectations, then randomized traffic and memory acks.
module tb_memu;
  logic        clock = 1'b0, reset = 1'b0;
  logic        valid_in = 1'b0, ready_in = 1'b1;
  logic [31:0] Ex_result_in = '0, rs2_value_in = '0, rd_value_in = '0, pc_in = '0;
  logic        mem_ren_in = 1'b0, mem_wen_in = 1'b0, R_wen_in = 1'b0, jump_flag_in = 1'b0;
  logic [2:0]  mem_op_in = '0;
  logic [4:0]  rd_in = '0;
  logic [3:0]  csr_wen_in = '0;
  logic        ready, valid_next, R_wen_out, mem_ren_out, jump_flag_out;
  logic [31:0] MEM_Rdata_out, Ex_result_out, rd_value_out, pc_out;
  logic [4:0]  rd_out;
  logic [3:0]  csr_wen_out, dmem_wstrb;
  logic        dmem_req, dmem_we, misalign_out;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [1:0]  dbg_state;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        rand_mode = 1'b0, dir_ack = 1'b0, rnd_ack = 1'b0;
  logic [31:0] dir_rdata = '0, rnd_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  assign dmem_ack   = rand_mode ? rnd_ack : dir_ack;
  assign dmem_rdata = rand_mode ? rnd_rdata : dir_rdata;

  memu dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ready(ready),
    .Ex_result_in(Ex_result_in), .rs2_value_in(rs2_value_in),
    .mem_ren_in(mem_ren_in), .mem_wen_in(mem_wen_in), .mem_op_in(mem_op_in),
    .rd_in(rd_in), .rd_value_in(rd_value_in), .csr_wen_in(csr_wen_in),
    .R_wen_in(R_wen_in), .jump_flag_in(jump_flag_in), .pc_in(pc_in),
    .valid_next(valid_next), .ready_in(ready_in),
    .MEM_Rdata_out(MEM_Rdata_out), .Ex_result_out(Ex_result_out),
    .rd_value_out(rd_value_out), .rd_out(rd_out), .csr_wen_out(csr_wen_out),
    .R_wen_out(R_wen_out), .mem_ren_out(mem_ren_out), .jump_flag_out(jump_flag_out),
    .pc_out(pc_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .misalign_out(misalign_out), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules, written as plain arithmetic on byte addresses.
  function automatic int acc_size(input logic [2:0] op, input logic ren);
    if (op == 3'd0 || (ren && op == 3'd4)) return 1;
    if (op == 3'd1 || (ren && op == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                          input logic [31:0] rd);
    logic [31:0] v;
    if (acc_size(op, 1'b1) == 1) begin
      v = (rd >> (8 * (addr % 4))) & 32'hFF;
      if (op == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (acc_size(op, 1'b1) == 2) begin
      v = (rd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (op == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else v = rd;
    return v;
  endfunction

  function automatic logic [31:0] exp_wstrb(input logic [2:0] op, input logic [31:0] addr);
    if (acc_size(op, 1'b0) == 1) return 32'd1 << (addr % 4);
    if (acc_size(op, 1'b0) == 2) return 32'd3 << (2 * ((addr / 2) % 2));
    return 32'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] d);
    if (acc_size(op, 1'b0) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (acc_size(op, 1'b0) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic f_mis(input logic ren, input logic wen, input logic [2:0] op,
                                 input logic [31:0] addr);
`ifdef MEMU_ALIGN_CHECK_EN
    return (ren || wen) && ((addr % acc_size(op, ren)) != 0);
`else
    return 1'b0 & (ren | wen | op[0] | addr[0]);
`endif
  endfunction

  // Model: a single slot that is empty, waiting on memory, or holding a result.
  logic        m_has = 1'b0, m_wait = 1'b0, m_mis = 1'b0;
  logic [31:0] m_ex, m_rs2, m_rdv, m_pc, m_rdata;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;
  logic [3:0]  m_csr;
  logic        m_ren, m_wen, m_rwen, m_jump, m_ready;
  logic [31:0] exp_q[$];

  assign m_ready = !m_has || (!m_wait && ready_in);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_has <= 1'b0; m_wait <= 1'b0; exp_q.delete();
    end else if (m_has && m_wait) begin
      if (dmem_ack) begin
        m_wait  <= 1'b0;
        m_rdata <= m_ren ? exp_load(m_op, m_ex, dmem_rdata) : 32'h0;
      end
    end else if (valid_in && m_ready) begin
      m_has  <= 1'b1;
      m_mis  <= f_mis(mem_ren_in, mem_wen_in, mem_op_in, Ex_result_in);
      m_wait <= (mem_ren_in || mem_wen_in) && !f_mis(mem_ren_in, mem_wen_in, mem_op_in, Ex_result_in);
      m_ex <= Ex_result_in; m_rs2 <= rs2_value_in; m_op <= mem_op_in;
      m_ren <= mem_ren_in; m_wen <= mem_wen_in; m_rd <= rd_in; m_rdv <= rd_value_in;
      m_csr <= csr_wen_in; m_rwen <= R_wen_in; m_jump <= jump_flag_in; m_pc <= pc_in;
      m_rdata <= 32'h0;
      exp_q.push_back(Ex_result_in);
    end else if (m_has && ready_in) begin
      m_has <= 1'b0;
    end
  end

  // Compare process: outputs settle mid-cycle, checked on the falling edge.
  always @(negedge clock) begin
    chk("ready", 32'(ready), 32'(m_ready));
    chk("valid_next", 32'(valid_next), 32'(m_has && !m_wait));
    chk("dmem_req", 32'(dmem_req), 32'(m_has && m_wait));
    if (m_has && !m_wait) begin
      chk("Ex_result_out", Ex_result_out, m_ex);
      chk("rd_value_out", rd_value_out, m_rdv);
      chk("rd_out", 32'(rd_out), 32'(m_rd));
      chk("csr_wen_out", 32'(csr_wen_out), 32'(m_csr));
      chk("R_wen_out", 32'(R_wen_out), 32'(m_rwen && !m_mis));
      chk("mem_ren_out", 32'(mem_ren_out), 32'(m_ren && !m_mis));
      chk("jump_flag_out", 32'(jump_flag_out), 32'(m_jump));
      chk("pc_out", pc_out, m_pc);
      chk("MEM_Rdata_out", MEM_Rdata_out, m_rdata);
      chk("misalign_out", 32'(misalign_out), 32'(m_mis));
    end
    if (m_has && m_wait) begin
      chk("dmem_addr", dmem_addr, m_ex & 32'hFFFF_FFFC);
      chk("dmem_we", 32'(dmem_we), 32'(m_wen));
      if (m_wen) begin
        chk("dmem_wstrb", 32'(dmem_wstrb), exp_wstrb(m_op, m_ex));
        chk("dmem_wdata", dmem_wdata, exp_wdata(m_op, m_rs2));
      end
    end
    if (valid_next && ready_in) begin
      if (exp_q.size() == 0) chk("handoff_spurious", 32'(valid_next), 32'd0);
      else chk("handoff_order", Ex_result_out, exp_q.pop_front());
    end
  end

  // Random memory responder: acks arrive at arbitrary times, even when idle.
  always @(posedge clock) begin
    #1;
    rnd_ack   <= ($urandom_range(0, 2) == 0);
    rnd_rdata <= $urandom;
  end

  // Driver tasks: called and return one time unit after a rising edge.
  task automatic send(input logic [31:0] ex, input logic [31:0] rs2, input logic ren,
                      input logic wen, input logic [2:0] op, input logic [4:0] rd,
                      input logic [31:0] rdv, input logic [3:0] csr, input logic rwen,
                      input logic jmp, input logic [31:0] pc, input logic rnd_rdy,
                      output int waited);
    logic acc;
    acc = 1'b0; waited = 0;
    valid_in = 1'b1; Ex_result_in = ex; rs2_value_in = rs2; mem_ren_in = ren;
    mem_wen_in = wen; mem_op_in = op; rd_in = rd; rd_value_in = rdv;
    csr_wen_in = csr; R_wen_in = rwen; jump_flag_in = jmp; pc_in = pc;
    while (!acc && waited < 200) begin
      if (rnd_rdy) ready_in = 1'($urandom_range(0, 1));
      #1;
      acc = m_ready;
      @(posedge clock); #1;
      waited++;
    end
    chk("accepted", 32'(acc), 32'd1);
  endtask

  task automatic step(input int n);
    valid_in = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    int w;
    // Model pins
    chk("model_lb", exp_load(3'd0, 32'h103, 32'h80AA_BBCC), 32'hFFFF_FF80);
    chk("model_sh_strb", exp_wstrb(3'd1, 32'h202), 32'hC);
    chk("model_sh_data", exp_wdata(3'd1, 32'h0000_ABCD), 32'hABCD_ABCD);

    // Reset values
    repeat (2) @(negedge clock);
    chk("rst_valid_next", 32'(valid_next), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_misalign", 32'(misalign_out), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ex", Ex_result_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // ADD passes straight through
    send(32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'd0, 5'd3, 32'h0000_1234, 4'h0, 1'b1, 1'b0,
         32'h8000_0000, 1'b0, w);
    valid_in = 1'b0;
    @(negedge clock);
    chk("add_valid", 32'(valid_next), 32'd1);
    chk("add_ex", Ex_result_out, 32'h0000_1234);
    chk("add_req", 32'(dmem_req), 32'd0);
    @(posedge clock); #1;

    // LB with slow ack
    send(32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'd0, 5'd4, 32'h0, 4'h0, 1'b1, 1'b0,
         32'h8000_0004, 1'b0, w);
    valid_in = 1'b0;
    @(negedge clock);
    chk("lb_req", 32'(dmem_req), 32'd1);
    chk("lb_addr", dmem_addr, 32'h0000_0100);
    chk("lb_ready", 32'(ready), 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    dir_ack = 1'b1; dir_rdata = 32'h80AA_BBCC;
    @(posedge clock); #1;
    dir_ack = 1'b0;
    @(negedge clock);
    chk("lb_valid", 32'(valid_next), 32'd1);
    chk("lb_data", MEM_Rdata_out, 32'hFFFF_FF80);
    @(posedge clock); #1;

    // SH lane 2
    send(32'h0000_0202, 32'h0000_ABCD, 1'b0, 1'b1, 3'd1, 5'd0, 32'h0, 4'h0, 1'b0, 1'b0,
         32'h8000_0008, 1'b0, w);
    valid_in = 1'b0;
    @(negedge clock);
    chk("sh_wstrb", 32'(dmem_wstrb), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(dmem_we), 32'd1);
    chk("sh_addr", dmem_addr, 32'h0000_0200);
    @(posedge clock); #1;
    dir_ack = 1'b1;
    @(posedge clock); #1;
    dir_ack = 1'b0;
    @(negedge clock);
    chk("sh_rdata_zero", MEM_Rdata_out, 32'd0);
    @(posedge clock); #1;

    // Downstream stall, then back-to-back
    step(2);
    ready_in = 1'b0;
    send(32'h0000_5555, 32'h0, 1'b0, 1'b0, 3'd0, 5'd7, 32'h0000_5555, 4'h0, 1'b1, 1'b1,
         32'h8000_0040, 1'b0, w);
    valid_in = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("stall_valid", 32'(valid_next), 32'd1);
      chk("stall_ready", 32'(ready), 32'd0);
      chk("stall_ex", Ex_result_out, 32'h0000_5555);
      chk("stall_pc", pc_out, 32'h8000_0040);
    end
    @(posedge clock); #1;
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(32'h100 + 32'(i), 32'h0, 1'b0, 1'b0, 3'd0, 5'(i), 32'h0, 4'h0, 1'b1, 1'b0,
           32'h9000_0000 + 32'(4 * i), 1'b0, w);
      chk("b2b_wait", 32'(w), 32'd1);
    end
    step(2);

    // Reset in the middle of a memory wait; ack after release is ignored
    send(32'h0000_0100, 32'h0, 1'b1, 1'b0, 3'd2, 5'd9, 32'h0, 4'h0, 1'b1, 1'b0,
         32'h8000_0080, 1'b0, w);
    valid_in = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("rstw_req", 32'(dmem_req), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1; dir_ack = 1'b1; dir_rdata = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    dir_ack = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("rstw_valid", 32'(valid_next), 32'd0);
    end
    @(posedge clock); #1;

    // Misaligned LW
    send(32'h0000_0102, 32'h0, 1'b1, 1'b0, 3'd2, 5'd10, 32'h0, 4'h0, 1'b1, 1'b0,
         32'h8000_00C0, 1'b0, w);
    valid_in = 1'b0;
    @(negedge clock);
`ifdef MEMU_ALIGN_CHECK_EN
    chk("mis_flag", 32'(misalign_out), 32'd1);
    chk("mis_valid", 32'(valid_next), 32'd1);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_rwen", 32'(R_wen_out), 32'd0);
    @(posedge clock); #1;
`else
    chk("lw_req", 32'(dmem_req), 32'd1);
    chk("lw_addr", dmem_addr, 32'h0000_0100);
    @(posedge clock); #1;
    dir_ack = 1'b1; dir_rdata = 32'h1122_3344;
    @(posedge clock); #1;
    dir_ack = 1'b0;
    @(negedge clock);
    chk("lw_data", MEM_Rdata_out, 32'h1122_3344);
    chk("lw_misalign", 32'(misalign_out), 32'd0);
    @(posedge clock); #1;
`endif
    step(2);

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) begin
        valid_in = 1'b0;
        ready_in = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
      end
      send($urandom, $urandom, kind == 1, kind == 2, 3'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b1, w);
    end
    ready_in = 1'b1;
    step(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
